axi4l_terminate_mr: RTL
=======================

# axi4l_terminate_mr

Multi-region AXI4-Lite slave terminator for unpopulated address space: decodes up to P_NREG address windows, each with its own constant read data and response code, and returns a default reply elsewhere. Read and write channels run independently and concurrently, hold valid until ready, and accept AW and W in any order. A sticky error-capture port reports the first non-OKAY access and a saturating error count. It sits on any interconnect slave port with no real component behind it.

## Interface
- P_AW, 32, address width
- P_DW, 32, data width (32 or 64)
- P_NREG, 2, number of decoded regions (1..8)
- P_START, '0, packed P_NREG*P_AW; region i start address (inclusive)
- P_END, '1, packed P_NREG*P_AW; region i end address (inclusive)
- P_RDATA, '0, packed P_NREG*P_DW; read data for region i
- P_RESP, '0, packed P_NREG*2; R/B response for region i
- P_ODATA, '0, read data outside all regions
- P_ORESP, 2'd3 (DECERR), response outside all regions
- P_CNT_W, 16, error counter width
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- axi_awaddr / axi_awvalid / axi_awready  in/in/out  P_AW/1/1  write address channel
- axi_wdata / axi_wstrb / axi_wvalid / axi_wready  in/in/in/out  P_DW/P_DW/8/1/1  write data channel (data and strobes ignored)
- axi_bresp / axi_bvalid / axi_bready  out/out/in  2/1/1  write response
- axi_araddr / axi_arvalid / axi_arready  in/in/out  P_AW/1/1  read address
- axi_rdata / axi_rresp / axi_rvalid / axi_rready  out/out/out/in  P_DW/2/1/1  read data
- err_clr  in  1  clears err_valid and err_cnt
- err_valid  out  1  sticky: a non-OKAY access occurred
- err_addr  out  P_AW  address of first captured non-OKAY access
- err_wr  out  1  1 = captured access was a write
- err_cnt  out  P_CNT_W  saturating count of non-OKAY accesses

## Operation
- Decode: region hit when START[i] <= addr <= END[i]; lowest index wins on overlap; no hit gives P_ODATA/P_ORESP. Unsigned P_AW-bit compares.
- Read FSM: R_IDLE (arready=1) -> on AR handshake register rdata/rresp, go R_RESP (rvalid=1) -> on rready go R_IDLE.
- Write FSM: W_IDLE (awready=1, wready=1); AW and W captured independently, each ready drops after its handshake; once both captured (same or different cycles) go W_RESP (bvalid=1, bresp from AW address) -> on bready go W_IDLE.
- Read and write paths are fully independent; no priority between them.
- Error capture on each AR handshake, and on each AW handshake whose decoded response != OKAY: err_cnt += number of events (0..2) that cycle, saturating at all-ones. If err_valid=0, latch address, set err_wr and err_valid; write wins when both occur in the same cycle.
- err_clr: clears err_valid and err_cnt; an event in the same cycle is applied after the clear (captured, err_cnt=1 or 2).

## Timing
- While areset=1 and for the reset cycle: all readies 0, rvalid=bvalid=0, rdata=0, rresp=0, bresp=0, err_* = 0; readies go high on the first cycle after deassertion.
- Reset mid-transaction drops pending responses without completing them.
- Read latency: AR handshake in cycle N -> rvalid in N+1; rdata/rresp stable while rvalid=1 and rready=0.
- Write latency: last of AW/W handshakes in cycle N -> bvalid in N+1; bresp stable until bready.
- Throughput: one transaction per 2 cycles per channel with ready held high.
- err_* update in the cycle after the triggering handshake.

## Structure
- Package axi4l_pkg: resp_t (logic [1:0]), constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Sub-module axi4l_term_decode: combinational address -> {hit, data, resp} over P_NREG regions; instantiated once for AR and once for AW.
- Top holds both FSMs, response registers and the error-capture logic.

## Test plan
- Read 0x1000 with region0 = 0x1000..0x1FFF, RDATA0=0xCAFE0001 -> rdata=0xCAFE0001, rresp=OKAY at N+1; err_cnt stays 0.
- Read 0x8000 with no hit, P_ORESP=DECERR -> rdata=P_ODATA, rresp=3, err_valid=1, err_addr=0x8000, err_wr=0, err_cnt=1.
- W three cycles before AW, bready=0 for 4 cycles -> bvalid the cycle after AW, held with stable bresp until bready.
- Simultaneous AR and AW, both out of range -> both channels respond at N+1, err_cnt=2, err_wr=1 captured; err_clr with a new error in the same cycle -> err_cnt=1.
- Overlapping regions 0 and 1 on address 0x1800 -> region 0 data and response returned.
- areset asserted while rvalid=1 -> next cycle rvalid=0, arready=0; after deassertion arready=1 and a new read completes normally.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite response definitions for the terminator slice.
// Contents: resp_t response code type, the four AXI response constants and
// a helper that flags any non-OKAY response.
package axi4l_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'd0;
    localparam resp_t EXOKAY = 2'd1;
    localparam resp_t SLVERR = 2'd2;
    localparam resp_t DECERR = 2'd3;

    // True for any response that should be logged by the error-capture port.
    function automatic logic resp_is_err(input resp_t r);
        return r != OKAY;
    endfunction

endpackage

// File: rtl/axi4l_term_decode.sv
// Combinational address decoder for the AXI4-Lite terminator.
// Ports:
//   addr_i  in   P_AW  address to decode
//   hit_o   out  1     address falls in at least one region
//   data_o  out  P_DW  read data of the winning region (P_ODATA on miss)
//   resp_o  out  2     response of the winning region (P_ORESP on miss)
module axi4l_term_decode
    import axi4l_pkg::*;
#(
    parameter int unsigned              P_AW    = 32,
    parameter int unsigned              P_DW    = 32,
    parameter int unsigned              P_NREG  = 2,
    parameter logic [P_NREG*P_AW-1:0]   P_START = '0,
    parameter logic [P_NREG*P_AW-1:0]   P_END   = '1,
    parameter logic [P_NREG*P_DW-1:0]   P_RDATA = '0,
    parameter logic [P_NREG*2-1:0]      P_RESP  = '0,
    parameter logic [P_DW-1:0]          P_ODATA = '0,
    parameter resp_t                    P_ORESP = DECERR
) (
    input  logic [P_AW-1:0] addr_i,
    output logic            hit_o,
    output logic [P_DW-1:0] data_o,
    output resp_t           resp_o
);

    // Scan from the highest index down so the lowest matching region wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = P_ODATA;
        resp_o = P_ORESP;
        for (int i = int'(P_NREG) - 1; i >= 0; i--) begin
            if ((addr_i >= P_START[i*P_AW +: P_AW]) &&
                (addr_i <= P_END[i*P_AW +: P_AW])) begin
                hit_o  = 1'b1;
                data_o = P_RDATA[i*P_DW +: P_DW];
                resp_o = resp_t'(P_RESP[i*2 +: 2]);
            end
        end
    end

endmodule

// File: rtl/axi4l_terminate_mr.sv
// Multi-region AXI4-Lite slave terminator. Answers every access with a
// constant per-region read data / response (default reply outside all
// regions) and records non-OKAY accesses on a sticky error-capture port.
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   axi_aw* / axi_w* / axi_b*     write address, data (ignored), response
//   axi_ar* / axi_r*              read address and data
//   err_clr                       clears err_valid and err_cnt
//   err_valid/addr/wr/cnt         first non-OKAY access and saturating count
module axi4l_terminate_mr
    import axi4l_pkg::*;
#(
    parameter int unsigned              P_AW    = 32,
    parameter int unsigned              P_DW    = 32,
    parameter int unsigned              P_NREG  = 2,
    parameter logic [P_NREG*P_AW-1:0]   P_START = '0,
    parameter logic [P_NREG*P_AW-1:0]   P_END   = '1,
    parameter logic [P_NREG*P_DW-1:0]   P_RDATA = '0,
    parameter logic [P_NREG*2-1:0]      P_RESP  = '0,
    parameter logic [P_DW-1:0]          P_ODATA = '0,
    parameter resp_t                    P_ORESP = DECERR,
    parameter int unsigned              P_CNT_W = 16
) (
    input  logic               aclk,
    input  logic               areset,

    input  logic [P_AW-1:0]    axi_awaddr,
    input  logic               axi_awvalid,
    output logic               axi_awready,

    input  logic [P_DW-1:0]    axi_wdata,
    input  logic [P_DW/8-1:0]  axi_wstrb,
    input  logic               axi_wvalid,
    output logic               axi_wready,

    output logic [1:0]         axi_bresp,
    output logic               axi_bvalid,
    input  logic               axi_bready,

    input  logic [P_AW-1:0]    axi_araddr,
    input  logic               axi_arvalid,
    output logic               axi_arready,

    output logic [P_DW-1:0]    axi_rdata,
    output logic [1:0]         axi_rresp,
    output logic               axi_rvalid,
    input  logic               axi_rready,

    input  logic               err_clr,
    output logic               err_valid,
    output logic [P_AW-1:0]    err_addr,
    output logic               err_wr,
    output logic [P_CNT_W-1:0] err_cnt
);

    typedef enum logic {R_IDLE, R_RESP} rstate_t;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    // Decoders for both address channels
    logic            ar_hit, aw_hit;
    logic [P_DW-1:0] ar_data, aw_data;
    resp_t           ar_resp, aw_resp;

    axi4l_term_decode #(
        .P_AW(P_AW), .P_DW(P_DW), .P_NREG(P_NREG),
        .P_START(P_START), .P_END(P_END), .P_RDATA(P_RDATA),
        .P_RESP(P_RESP), .P_ODATA(P_ODATA), .P_ORESP(P_ORESP)
    ) u_dec_ar (
        .addr_i (axi_araddr),
        .hit_o  (ar_hit),
        .data_o (ar_data),
        .resp_o (ar_resp)
    );

    axi4l_term_decode #(
        .P_AW(P_AW), .P_DW(P_DW), .P_NREG(P_NREG),
        .P_START(P_START), .P_END(P_END), .P_RDATA(P_RDATA),
        .P_RESP(P_RESP), .P_ODATA(P_ODATA), .P_ORESP(P_ORESP)
    ) u_dec_aw (
        .addr_i (axi_awaddr),
        .hit_o  (aw_hit),
        .data_o (aw_data),
        .resp_o (aw_resp)
    );

    // Write data/strobes and hit flags carry no information for a terminator.
    logic unused_sigs;
    assign unused_sigs = ^{axi_wdata, axi_wstrb, ar_hit, aw_hit, aw_data};

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t         rstate_q;
    logic            arready_q;
    logic            rvalid_q;
    logic [P_DW-1:0] rdata_q;
    resp_t           rresp_q;
    logic            ar_hs;

    assign ar_hs = axi_arvalid & arready_q;

    // Read FSM; arready rises one cycle after reset release.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rdata_q   <= ar_data;
                        rresp_q   <= ar_resp;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t wstate_q;
    logic    awready_q, wready_q;
    logic    aw_done_q, w_done_q;
    resp_t   aw_resp_q;
    logic    bvalid_q;
    resp_t   bresp_q;
    logic    aw_hs, w_hs, aw_got, w_got;

    assign aw_hs  = axi_awvalid & awready_q;
    assign w_hs   = axi_wvalid & wready_q;
    assign aw_got = aw_done_q | aw_hs;
    assign w_got  = w_done_q | w_hs;

    // Write FSM; AW and W are collected independently in W_IDLE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_resp_q <= OKAY;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_got && w_got) begin
                        // Response comes from this cycle's AW if it just arrived.
                        bresp_q   <= aw_hs ? aw_resp : aw_resp_q;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        wstate_q  <= W_RESP;
                    end else begin
                        aw_done_q <= aw_got;
                        w_done_q  <= w_got;
                        awready_q <= ~aw_got;
                        wready_q  <= ~w_got;
                        if (aw_hs) begin
                            aw_resp_q <= aw_resp;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error capture
    // ------------------------------------------------------------------
    logic               err_valid_q, err_valid_d;
    logic [P_AW-1:0]    err_addr_q, err_addr_d;
    logic               err_wr_q, err_wr_d;
    logic [P_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic               ar_err, aw_err;
    logic [P_CNT_W:0]   cnt_sum;
    logic [P_CNT_W-1:0] cnt_base;
    logic               valid_base;

    assign ar_err = ar_hs & resp_is_err(ar_resp);
    assign aw_err = aw_hs & resp_is_err(aw_resp);

    // Clear is applied first, then this cycle's events are counted/captured.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_wr_d    = err_wr_q;
        err_cnt_d   = err_cnt_q;

        cnt_base   = err_clr ? '0 : err_cnt_q;
        valid_base = err_clr ? 1'b0 : err_valid_q;
        cnt_sum    = {1'b0, cnt_base} + (P_CNT_W+1)'(ar_err) + (P_CNT_W+1)'(aw_err);

        err_cnt_d   = cnt_sum[P_CNT_W] ? '1 : cnt_sum[P_CNT_W-1:0];
        err_valid_d = valid_base;

        if (!valid_base && (ar_err || aw_err)) begin
            err_valid_d = 1'b1;
            err_wr_d    = aw_err;
            err_addr_d  = aw_err ? axi_awaddr : axi_araddr;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_wr_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_wr_q    <= err_wr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign err_valid   = err_valid_q;
    assign err_addr    = err_addr_q;
    assign err_wr      = err_wr_q;
    assign err_cnt     = err_cnt_q;

endmodule
